hilo_mult_unit: RTL and testbench
=================================

HILO_MULT_UNIT -- requirements
Module: hilo_mult_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
REQ-002 The block SHALL provide these remaining ports:
- enhilo_EX  in  1  start request from the EX-stage control unit (mult/multu)
- signed_EX  in  1  1 = mult (signed), 0 = multu; sampled with enhilo_EX
- a_EX  in  32  rs operand
- b_EX  in  32  rt operand
- regsel_EX  in  2  1 = mfhi, 2 = mflo, 0/3 = no HI/LO read
- hilo_rd  out  32  HI/LO read data returned to the EX stage
- hi  out  32  architectural HI register
- lo  out  32  architectural LO register
- busy  out  1  multiply in progress
- stall_req  out  1  EX-stage stall request
- done  out  1  one-cycle pulse in the cycle HI/LO are committed

Function
REQ-003 The block SHALL use three states, IDLE, RUN and FIX, with a 5-bit iteration counter.
REQ-004 In IDLE, with enhilo_EX=1, the block SHALL capture |a|, |b| (magnitudes only if signed_EX=1, else raw values) and the product sign (a[31]^b[31] if signed, else 0), clear the 64-bit accumulator, set counter=0, and go to RUN.
REQ-005 In RUN, each cycle SHALL perform one shift-add step of the 32x32 unsigned multiply on the LSB of the multiplier; after the step with counter=31 the block SHALL go to FIX.
REQ-006 In FIX, the block SHALL write the accumulator, two's-complement negated across 64 bits when the sign is 1, into {hi, lo}, pulse done=1 and return to IDLE.
REQ-007 Latency: start accepted at edge N; hi/lo update and done=1 at edge N+33; busy=1 from after edge N until edge N+33.
REQ-008 Magnitude of 0x80000000 SHALL be 2^31 (unsigned 32-bit); no overflow path.
REQ-009 A zero operand SHALL give {hi,lo}=0 regardless of sign.
REQ-010 hi/lo SHALL hold their previous values during RUN and change only in FIX or on reset.
REQ-011 hilo_rd SHALL be combinational: hi when regsel_EX=1, lo when regsel_EX=2, 0 otherwise.
REQ-012 stall_req SHALL be 1 when state!=IDLE and (regsel_EX is 1 or 2, or enhilo_EX=1); otherwise 0.
REQ-013 stall_req SHALL be 0 in the FIX cycle for reads; the read sees the new value from the following cycle onward.
REQ-014 enhilo_EX while state!=IDLE SHALL be ignored, with no effect on the running operation; the EX stage holds the instruction under stall_req.
REQ-015 enhilo_EX and a nonzero regsel_EX in the same IDLE cycle SHALL return the old hi/lo on hilo_rd and start the multiply.
REQ-016 regsel_EX=3 SHALL never stall and SHALL read 0.

Reset
REQ-017 While rst=1, the block SHALL force state=IDLE, counter=0, accumulator=0, hi=0, lo=0, busy=0, done=0 and stall_req=0, immediately and asynchronously.
REQ-018 Reset asserted mid-RUN or in FIX SHALL abort the operation with no commit to hi/lo.
REQ-019 After rst falls, the block SHALL accept a start on the first clock edge.

Verification
REQ-020 multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done at edge N+33, busy=0 after it.
REQ-021 mult 0xFFFFFFFF (-1) x 0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFFB; the same operands as multu -> hi=0x00000004, lo=0xFFFFFFFB.
REQ-022 mult 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000; mult 0 x 0x80000000 -> hi=lo=0.
REQ-023 mflo (regsel_EX=2) held from cycle N+5 -> stall_req=1 through edge N+32, 0 in FIX, hilo_rd = new lo on the following cycle.
REQ-024 Second enhilo_EX at cycle N+10 -> stall_req=1, first result unchanged; after rst pulse at cycle N+20 -> busy=0, hi=lo=0, no done pulse.

Source files
------------

// File: rtl/hilo_mult_if.sv
// hilo_if -- EX-stage <-> HI/LO multiply unit bundle.
//   master: EX stage (drives start/operands/read select, receives results)
//   slave : hilo_mult_unit
//   enhilo_EX/signed_EX/a_EX/b_EX : multiply start request and operands
//   regsel_EX                     : 1=mfhi, 2=mflo, 0/3=no read
//   hilo_rd/hi/lo                 : read data and architectural HI/LO
//   busy/stall_req/done           : status back to the pipeline
interface hilo_if;
  logic        enhilo_EX;
  logic        signed_EX;
  logic [31:0] a_EX;
  logic [31:0] b_EX;
  logic [1:0]  regsel_EX;
  logic [31:0] hilo_rd;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_req;
  logic        done;

  modport master (
    output enhilo_EX, signed_EX, a_EX, b_EX, regsel_EX,
    input  hilo_rd, hi, lo, busy, stall_req, done
  );

  modport slave (
    input  enhilo_EX, signed_EX, a_EX, b_EX, regsel_EX,
    output hilo_rd, hi, lo, busy, stall_req, done
  );
endinterface

// File: rtl/hilo_mult_unit.sv
// hilo_mult_unit -- iterative 32x32 multiplier owning the HI/LO registers.
// One shift-add step per cycle on operand magnitudes, sign applied at the end.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : hilo_if.slave (start/operands/read select in, hilo_rd/hi/lo/status out)
// Timing: start at edge N, RUN covers edges N+1..N+32, FIX cycle commits
// {hi,lo} at edge N+33; done is high during the FIX cycle.
module hilo_mult_unit (
  input  logic  clk,
  input  logic  rst,
  hilo_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t      r_state, w_next;
  logic [4:0]  r_cnt;
  logic [63:0] r_acc;
  logic [63:0] r_mcand;   // multiplicand, shifted left each step
  logic [31:0] r_mplier;  // multiplier, shifted right; LSB drives the add
  logic        r_neg;
  logic [31:0] r_hi, r_lo;

  logic        w_start;
  logic        w_rd;
  logic [31:0] w_amag, w_bmag;

  assign w_start = (r_state == S_IDLE) && bus.enhilo_EX;
  assign w_rd    = (bus.regsel_EX == 2'd1) || (bus.regsel_EX == 2'd2);

  // 32-bit unsigned negate: magnitude of 0x80000000 stays 0x80000000 (2^31)
  assign w_amag = (bus.signed_EX && bus.a_EX[31]) ? (~bus.a_EX + 32'd1) : bus.a_EX;
  assign w_bmag = (bus.signed_EX && bus.b_EX[31]) ? (~bus.b_EX + 32'd1) : bus.b_EX;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.enhilo_EX) w_next = S_RUN;
      S_RUN:   if (r_cnt == 5'd31) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // outputs; reads only stall while RUN, a start request stalls in any busy state
  always_comb begin
    bus.busy      = (r_state != S_IDLE);
    bus.done      = (r_state == S_FIX);
    bus.stall_req = ((r_state == S_RUN) && w_rd) ||
                    ((r_state != S_IDLE) && bus.enhilo_EX);
    case (bus.regsel_EX)
      2'd1:    bus.hilo_rd = r_hi;
      2'd2:    bus.hilo_rd = r_lo;
      default: bus.hilo_rd = 32'd0;
    endcase
  end

  assign bus.hi = r_hi;
  assign bus.lo = r_lo;

  // datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= 5'd0;
      r_acc    <= 64'd0;
      r_mcand  <= 64'd0;
      r_mplier <= 32'd0;
      r_neg    <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) begin
          r_mcand  <= {32'd0, w_amag};
          r_mplier <= w_bmag;
          r_neg    <= bus.signed_EX & (bus.a_EX[31] ^ bus.b_EX[31]);
          r_acc    <= 64'd0;
          r_cnt    <= 5'd0;
        end
        S_RUN: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 5'd1;
        end
        S_FIX: begin
          // zero accumulator negates to zero, so sign never leaks into a 0 result
          {r_hi, r_lo} <= r_neg ? (~r_acc + 64'd1) : r_acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mult_unit.sv
module tb_hilo_mult_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hilo_if u_if ();
  hilo_mult_unit u_dut (.clk(clk), .rst(rst), .bus(u_if));

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // reference product from plain integer arithmetic
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic logic [31:0] rd_exp(input logic [1:0] sel);
    return (sel == 2'd1) ? m_hi : (sel == 2'd2) ? m_lo : 32'd0;
  endfunction

  function automatic logic [31:0] pick;
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // start a multiply; read select rs held from cycle N+5, optional stray start at N+10
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic [1:0] rs, input logic junk);
    logic [63:0] p;
    logic [1:0]  pre;
    logic        exp_stall;
    p   = ref_prod(a, b, sgn);
    pre = 2'($urandom_range(0, 3));
    u_if.regsel_EX = pre;
    u_if.enhilo_EX = 1'b1;
    u_if.signed_EX = sgn;
    u_if.a_EX      = a;
    u_if.b_EX      = b;
    #1;
    chk("idle_stall", u_if.stall_req, 0);
    chk("idle_rd", u_if.hilo_rd, rd_exp(pre));
    chk("idle_busy", u_if.busy, 0);
    tick; // edge N
    u_if.enhilo_EX = 1'b0;
    u_if.regsel_EX = 2'd0;
    u_if.a_EX      = $urandom;
    u_if.b_EX      = $urandom;
    u_if.signed_EX = 1'($urandom);
    #1;
    chk("n_busy", u_if.busy, 1);
    chk("n_stall", u_if.stall_req, 0);
    for (int k = 1; k <= 32; k++) begin
      tick; // after edge N+k
      if (k == 5) u_if.regsel_EX = rs;
      if (k == 10 && junk) begin
        u_if.enhilo_EX = 1'b1;
        u_if.a_EX      = $urandom;
        u_if.signed_EX = ~sgn;
      end
      #1;
      exp_stall = (k >= 5 && k < 32 && (rs == 2'd1 || rs == 2'd2)) || (junk && k >= 10);
      chk("run_busy", u_if.busy, 1);
      chk("run_done", u_if.done, (k == 32));
      chk("run_stall", u_if.stall_req, exp_stall);
      chk("run_rd", u_if.hilo_rd, (k >= 5) ? rd_exp(rs) : 32'd0);
      chk("run_hi", u_if.hi, m_hi);
      chk("run_lo", u_if.lo, m_lo);
      if (k == 32) u_if.enhilo_EX = 1'b0;
    end
    tick; // edge N+33
    {m_hi, m_lo} = p;
    chk("fin_done", u_if.done, 0);
    chk("fin_busy", u_if.busy, 0);
    chk("fin_stall", u_if.stall_req, 0);
    chk("fin_hi", u_if.hi, m_hi);
    chk("fin_lo", u_if.lo, m_lo);
    chk("fin_rd", u_if.hilo_rd, rd_exp(rs));
    u_if.regsel_EX = 2'd0;
  endtask

  // start a multiply and reset it after edge N+at_k; nothing may commit
  task automatic run_abort(input logic [31:0] a, input logic [31:0] b, input int at_k,
                           input int watch);
    int n_done;
    u_if.enhilo_EX = 1'b1;
    u_if.signed_EX = 1'b1;
    u_if.a_EX      = a;
    u_if.b_EX      = b;
    tick;
    u_if.enhilo_EX = 1'b0;
    for (int k = 1; k <= at_k; k++) tick;
    rst = 1'b1;
    #1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    chk("rst_busy", u_if.busy, 0);
    chk("rst_done", u_if.done, 0);
    chk("rst_hi", u_if.hi, 0);
    chk("rst_lo", u_if.lo, 0);
    u_if.regsel_EX = 2'd1;
    #1;
    chk("rst_stall", u_if.stall_req, 0);
    u_if.regsel_EX = 2'd0;
    tick;
    rst = 1'b0;
    n_done = 0;
    for (int k = 0; k < watch; k++) begin
      tick;
      if (u_if.done) n_done++;
    end
    if (watch > 0) begin
      chk("abort_nodone", n_done, 0);
      chk("abort_hi", u_if.hi, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    u_if.enhilo_EX = 1'b0;
    u_if.signed_EX = 1'b0;
    u_if.a_EX      = 32'd0;
    u_if.b_EX      = 32'd0;
    u_if.regsel_EX = 2'd0;
    #1;
    chk("por_busy", u_if.busy, 0);
    chk("por_done", u_if.done, 0);
    chk("por_stall", u_if.stall_req, 0);
    chk("por_hi", u_if.hi, 0);
    chk("por_lo", u_if.lo, 0);
    tick;
    tick;
    rst = 1'b0;

    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2'd2, 1'b0);
    chk("r020_hi", u_if.hi, 32'hFFFF_FFFE);
    chk("r020_lo", u_if.lo, 32'h0000_0001);
    run_mult(32'hFFFF_FFFF, 32'h0000_0005, 1'b1, 2'd1, 1'b1);
    chk("r021s_hi", u_if.hi, 32'hFFFF_FFFF);
    chk("r021s_lo", u_if.lo, 32'hFFFF_FFFB);
    run_mult(32'hFFFF_FFFF, 32'h0000_0005, 1'b0, 2'd3, 1'b0);
    chk("r021u_hi", u_if.hi, 32'h0000_0004);
    chk("r021u_lo", u_if.lo, 32'hFFFF_FFFB);
    run_mult(32'h8000_0000, 32'h8000_0000, 1'b1, 2'd2, 1'b1);
    chk("r022_hi", u_if.hi, 32'h4000_0000);
    chk("r022_lo", u_if.lo, 32'h0000_0000);
    run_mult(32'h0000_0000, 32'h8000_0000, 1'b1, 2'd1, 1'b0);
    chk("r022z_hi", u_if.hi, 32'd0);
    chk("r022z_lo", u_if.lo, 32'd0);

    run_mult(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 2'd0, 1'b0);
    run_abort(32'h7654_3210, 32'h0000_0003, 20, 40);
    run_mult(32'h8000_0000, 32'h0000_0001, 1'b1, 2'd2, 1'b0);
    run_abort(32'hDEAD_BEEF, 32'h0000_0007, 32, 0);
    run_mult(32'hFFFF_FFFE, 32'h7FFF_FFFF, 1'b1, 2'd1, 1'b1);

    for (int i = 0; i < 20; i++)
      run_mult(pick(), pick(), 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
